// File: rtl/fpu_pkg.sv
// Shared FPU significand parameters and the iterative divider's state encoding.
// Defaults here set the single-precision widths used across the divide path.
package fpu_pkg;
   localparam int N     = 24;
   localparam int QW    = N + 2;
   localparam int CNT_W = $clog2(QW + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/mantissa_divider_if.sv
// Operand/result handshake bundle between the divide path and the significand divider.
// master drives operands and out_ready; slave is the divider.
interface mantissa_divider_if
   import fpu_pkg::*;
#(
   parameter int N  = fpu_pkg::N,
   parameter int QW = N + 2
);
   logic          in_valid;
   logic          in_ready;
   logic [N-2:0]  frac1;
   logic [N-2:0]  frac2;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quot;
   logic          sticky;

   modport master (
      output in_valid, frac1, frac2, out_ready,
      input  in_ready, out_valid, quot, sticky
   );

   modport slave (
      input  in_valid, frac1, frac2, out_ready,
      output in_ready, out_valid, quot, sticky
   );
endinterface

// File: rtl/mantissa_divider_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift. Purely combinational.
// rem is one bit wider than div so rem < 2*div survives the shift without overflow.
module div_step #(
   parameter int N = 24
) (
   input  logic [N:0]   rem,
   input  logic [N-1:0] div,
   output logic         qbit,
   output logic [N:0]   next_rem
);
   logic [N:0] sel;

   assign qbit     = (rem >= {1'b0, div});
   assign sel      = qbit ? (rem - {1'b0, div}) : rem;
   assign next_rem = sel << 1;
endmodule

// File: rtl/mantissa_divider.sv
// Restoring significand divider: 1.frac1 / 1.frac2, one quotient bit per clock, QW cycles after accept.
// Result is held in DONE until out_ready; operands are only taken in IDLE.
module mantissa_divider
   import fpu_pkg::*;
#(
   parameter int N = fpu_pkg::N
) (
   input  logic             clk,
   input  logic             rst,
   mantissa_divider_if.slave bus
);
   localparam int QW    = N + 2;
   localparam int CNT_W = $clog2(QW + 1);

   div_state_t       state_q, state_d;
   logic [N:0]       rem_q, rem_d;
   logic [N-1:0]     div_q, div_d;
   logic [QW-1:0]    quot_q, quot_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic             qbit;
   logic [N:0]       next_rem;

   div_step #(.N(N)) u_step (
      .rem      (rem_q),
      .div      (div_q),
      .qbit     (qbit),
      .next_rem (next_rem)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      div_d       = div_q;
      quot_d      = quot_q;
      cnt_d       = cnt_q;
      sticky_d    = sticky_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               rem_d      = {1'b0, 1'b1, bus.frac1};
               div_d      = {1'b1, bus.frac2};
               quot_d     = '0;
               cnt_d      = CNT_W'(QW);
               in_ready_d = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            // cnt counts down from QW, so bit cnt-1 is the one this step resolves
            quot_d = quot_q | (QW'(qbit) << (cnt_q - CNT_W'(1)));
            rem_d  = next_rem;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               sticky_d    = (next_rem != '0);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         div_q       <= '0;
         quot_q      <= '0;
         cnt_q       <= '0;
         sticky_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         div_q       <= div_d;
         quot_q      <= quot_d;
         cnt_q       <= cnt_d;
         sticky_q    <= sticky_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quot      = quot_q;
   assign bus.sticky    = sticky_q;
endmodule

// File: tb/tb_mantissa_divider.sv
// Bench for mantissa_divider: exact-integer quotient model checked every cycle plus literal vectors.
module tb_mantissa_divider;
   localparam int N  = 24;
   localparam int QW = N + 2;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   mantissa_divider_if #(.N(N)) bus ();

   mantissa_divider #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [QW-1:0] q;
      logic          s;
      int            acc;
   } exp_t;

   exp_t exp_q[$];
   bit   seen;

   // Quotient of significands a/b scaled by 2^(QW-1): floor gives quot, remainder gives sticky.
   function automatic exp_t model(logic [N-2:0] f1, logic [N-2:0] f2, int acc);
      exp_t    e;
      longint  a;
      longint  b;
      longint  num;
      a     = longint'({1'b1, f1});
      b     = longint'({1'b1, f2});
      num   = a << (QW - 1);
      e.q   = QW'(num / b);
      e.s   = ((num % b) != 0);
      e.acc = acc;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         seen = 1'b0;
      end else begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
               if (!seen) begin
                  chk("latency", 64'(cyc - exp_q[0].acc), 64'(QW));
                  seen = 1'b1;
               end
               chk("model_quot", 64'(bus.quot), 64'(exp_q[0].q));
               chk("model_sticky", 64'(bus.sticky), 64'(exp_q[0].s));
               chk("in_ready_while_done", 64'(bus.in_ready), 64'd0);
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.frac1, bus.frac2, cyc + 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-2:0] f1, input logic [N-2:0] f2, input bit keep);
      bit taken;
      taken        = 1'b0;
      bus.frac1    = f1;
      bus.frac2    = f2;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         taken = bus.in_ready;
         tick();
         if (taken) break;
      end
      if (!taken) chk("accept_timeout", 64'd0, 64'd1);
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic directed(input string nm, input logic [N-2:0] f1, input logic [N-2:0] f2,
                           input logic [QW-1:0] eq, input logic es);
      send(f1, f2, 1'b0);
      wait_valid();
      chk({nm, "_quot"}, 64'(bus.quot), 64'(eq));
      chk({nm, "_sticky"}, 64'(bus.sticky), 64'(es));
      release_result();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.frac1     = '0;
      bus.frac2     = '0;
      rst           = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_quot", 64'(bus.quot), 64'd0);
      chk("rst_sticky", 64'(bus.sticky), 64'd0);

      // out_ready with nothing pending must not disturb IDLE
      bus.out_ready = 1'b1;
      repeat (3) tick();
      bus.out_ready = 1'b0;
      chk("idle_out_ready_in_ready", 64'(bus.in_ready), 64'd1);
      chk("idle_out_ready_out_valid", 64'(bus.out_valid), 64'd0);

      directed("one_over_one", 23'h000000, 23'h000000, 26'h2000000, 1'b0);
      directed("one_over_1p5", 23'h000000, 23'h400000, 26'h1555555, 1'b1);
      directed("1p5_over_one", 23'h400000, 23'h000000, 26'h3000000, 1'b0);
      directed("max_over_one", 23'h7FFFFF, 23'h000000, 26'h3FFFFFC, 1'b0);

      // Backpressure, with stray operands offered during CALC and DONE
      send(23'h000000, 23'h000000, 1'b0);
      repeat (5) tick();
      bus.frac1 = 23'h7FFFFF; bus.frac2 = 23'h123456; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_valid();
      bus.frac1 = 23'h2AAAAA; bus.frac2 = 23'h000001; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_quot", 64'(bus.quot), 64'h2000000);
         chk("bp_sticky", 64'(bus.sticky), 64'd0);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         tick();
      end
      release_result();
      chk("bp_after_in_ready", 64'(bus.in_ready), 64'd1);

      // Reset mid-divide drops the result
      send(23'h000000, 23'h400000, 1'b0);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_quot", 64'(bus.quot), 64'd0);
      directed("post_abort", 23'h000000, 23'h400000, 26'h1555555, 1'b1);

      // Back-to-back with in_valid and out_ready both held high
      bus.out_ready = 1'b1;
      send(23'h000000, 23'h000000, 1'b1);
      send(23'h000000, 23'h400000, 1'b1);
      send(23'h400000, 23'h000000, 1'b0);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      bus.out_ready = 1'b0;
      chk("b2b_drained", 64'(exp_q.size()), 64'd0);

      for (int k = 0; k < 16; k++) begin
         send(N'($urandom) & 23'h7FFFFF, N'($urandom) & 23'h7FFFFF, 1'b0);
         wait_valid();
         repeat ($urandom_range(0, 3)) tick();
         release_result();
         repeat ($urandom_range(0, 2)) tick();
      end

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      chk("final_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
